// File: rtl/pr_decouple_ctrl.sv
// ---------------------------------------------------------------------------
// pr_decouple_ctrl
//
// Sequences a partial-reconfiguration swap of one reconfigurable module (RM):
// isolate its outputs, hold them isolated while in-flight data drains, put the
// RM in reset and kick the bitstream loader, wait for the loader verdict, then
// release reset, let the new RM settle and finally recouple its outputs.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   swap_req    debounced swap request; its rising edge starts a swap
//   load_done   loader: partial bitstream loaded
//   load_err    loader: load failed
//   rm_out      raw 4-bit output of the RM
//   load_start  one-cycle pulse while in LOAD
//   decouple    1 = RM outputs isolated
//   rm_rst_n    active-low reset to the RM
//   led_out     registered, isolated RM output (SAFE_VALUE while decoupled)
//   swap_busy   high in every state except IDLE and FAULT
//   status      00 no swap yet, 01 last swap ok, 10 load error, 11 timeout
//   swap_cnt    count of successful swaps (wraps 255 -> 0)
//
// Configuration macro
//   PR_DECOUPLE_RETRY_EN  when defined, the first load error or timeout of a
//                         swap re-enters LOAD once instead of faulting.
// ---------------------------------------------------------------------------
module pr_decouple_ctrl #(
  parameter int unsigned DRAIN_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned TIMEOUT_W     = 24,
  parameter logic [3:0]  SAFE_VALUE    = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       swap_req,
  input  logic       load_done,
  input  logic       load_err,
  input  logic [3:0] rm_out,
  output logic       load_start,
  output logic       decouple,
  output logic       rm_rst_n,
  output logic [3:0] led_out,
  output logic       swap_busy,
  output logic [1:0] status,
  output logic [7:0] swap_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISOLATE = 3'd1,
    S_LOAD    = 3'd2,
    S_WAIT    = 3'd3,
    S_SETTLE  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  // The timer is incremented on every WAIT edge, so it becomes all-ones on
  // the very edge that leaves WAIT for FAULT when the pre-terminal value is
  // seen. WAIT therefore lasts exactly 2^TIMEOUT_W-1 cycles.
  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] TIMER_ONE = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] TIMER_PRE = TIMER_MAX - TIMER_ONE;

  state_t                state;
  state_t                state_nxt;
  logic                  swap_req_p0;
  logic                  rise;
  logic [7:0]            phase_cnt;
  logic [TIMEOUT_W-1:0]  timer;
  logic                  fail_err;
  logic                  fail_tmo;
  logic                  swap_ok;
  logic                  fault_enter;
`ifdef PR_DECOUPLE_RETRY_EN
  logic                  retry_used;
  logic                  retry_set;
`endif

  // A rise is swap_req high now and low at the previous edge. It is only
  // acted on in IDLE/FAULT; elsewhere it is dropped, never queued.
  assign rise = swap_req & ~swap_req_p0;

  // --- next-state logic ---
  always_comb begin
    state_nxt = state;
    fail_err  = 1'b0;
    fail_tmo  = 1'b0;
    swap_ok   = 1'b0;
`ifdef PR_DECOUPLE_RETRY_EN
    retry_set = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rise) state_nxt = S_ISOLATE;
      end
      S_ISOLATE: begin
        if (phase_cnt == DRAIN_LAST) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // Loader handshakes are deliberately ignored for this one cycle.
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Priority: error, then done, then timeout.
        if (load_err)                state_nxt = S_FAULT;
        else if (load_done)          state_nxt = S_SETTLE;
        else if (timer == TIMER_PRE) state_nxt = S_FAULT;
        fail_err = load_err;
        fail_tmo = ~load_err & ~load_done & (timer == TIMER_PRE);
`ifdef PR_DECOUPLE_RETRY_EN
        if ((fail_err || fail_tmo) && !retry_used) begin
          state_nxt = S_LOAD;
          retry_set = 1'b1;
        end
`endif
      end
      S_SETTLE: begin
        if (phase_cnt == SETTLE_LAST) begin
          state_nxt = S_IDLE;
          swap_ok   = 1'b1;
        end
      end
      S_FAULT: begin
        if (rise) state_nxt = S_ISOLATE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign fault_enter = (state == S_WAIT) && (state_nxt == S_FAULT);

  // --- state register ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // --- registered outputs, counters and edge detector ---
  // Outputs are decoded from state_nxt so they change on the edge that
  // enters the state, not one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_req_p0 <= 1'b0;
      decouple    <= 1'b0;
      rm_rst_n    <= 1'b0;
      load_start  <= 1'b0;
      swap_busy   <= 1'b0;
      led_out     <= SAFE_VALUE;
      status      <= 2'b00;
      swap_cnt    <= 8'd0;
      phase_cnt   <= 8'd0;
      timer       <= '0;
    end else begin
      swap_req_p0 <= swap_req;
      decouple    <= (state_nxt != S_IDLE);
      rm_rst_n    <= !(state_nxt inside {S_LOAD, S_WAIT, S_FAULT});
      load_start  <= (state_nxt == S_LOAD);
      swap_busy   <= !(state_nxt inside {S_IDLE, S_FAULT});
      // Isolation uses the decouple value already in the register, which
      // gives the one-cycle output latency.
      led_out     <= decouple ? SAFE_VALUE : rm_out;

      if (state_nxt != state)
        phase_cnt <= 8'd0;
      else if (state == S_ISOLATE || state == S_SETTLE)
        phase_cnt <= phase_cnt + 8'd1;

      // Cleared in every other state, so WAIT is always entered with 0.
      timer <= (state == S_WAIT) ? timer + TIMER_ONE : '0;

      if (swap_ok) begin
        status   <= 2'b01;
        swap_cnt <= swap_cnt + 8'd1;
      end else if (fault_enter) begin
        status   <= fail_err ? 2'b10 : 2'b11;
      end
    end
  end

`ifdef PR_DECOUPLE_RETRY_EN
  // --- retry bookkeeping: one reload per swap attempt ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retry_used <= 1'b0;
    else if (state_nxt == S_ISOLATE && state != S_ISOLATE)
      retry_used <= 1'b0;
    else if (retry_set)
      retry_used <= 1'b1;
  end
`endif

endmodule

// File: doc/pr_decouple_ctrl.md
PR_DECOUPLE_CTRL -- requirements
Module: pr_decouple_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 16: cycles outputs stay isolated before the RM is put in reset (range 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 8: cycles after RM reset release before outputs are recoupled (range 1..255).
REQ-003 Parameter TIMEOUT_W, default 24: width of the load-wait timer; timeout fires after 2^TIMEOUT_W-1 cycles in WAIT.
REQ-004 Parameter SAFE_VALUE, default 4'b0000: value driven on led_out while decoupled.
REQ-005 clk  in  1  system clock; all logic is rising-edge.
REQ-006 rst_n  in  1  reset: asynchronous assert, active-low.
REQ-007 swap_req  in  1  synchronous, already debounced swap request; its rising edge starts a swap.
REQ-008 load_done  in  1  loader reports partial bitstream loaded.
REQ-009 load_err  in  1  loader reports load failure.
REQ-010 rm_out  in  4  raw output of the reconfigurable module.
REQ-011 load_start  out  1  high for exactly the one cycle spent in LOAD.
REQ-012 decouple  out  1  1 = RM outputs isolated.
REQ-013 rm_rst_n  out  1  active-low reset to the RM.
REQ-014 led_out  out  4  registered, isolated RM output.
REQ-015 swap_busy  out  1  high in every state except IDLE and FAULT.
REQ-016 status  out  2  00 no swap yet, 01 last swap ok, 10 load_err, 11 timeout.
REQ-017 swap_cnt  out  8  count of successful swaps.

Function
REQ-018 Rising edge = swap_req 1 at current edge, 0 at previous edge; recognised only in IDLE or FAULT; otherwise ignored, not queued.
REQ-019 States: IDLE, ISOLATE, LOAD, WAIT, SETTLE, FAULT.
REQ-020 IDLE: decouple=0, rm_rst_n=1; on rising edge -> ISOLATE.
REQ-021 ISOLATE: decouple=1, rm_rst_n=1; stays exactly DRAIN_CYCLES cycles, then -> LOAD.
REQ-022 LOAD: decouple=1, rm_rst_n=0, load_start=1; one cycle, then -> WAIT; load_done/load_err ignored in LOAD.
REQ-023 WAIT: decouple=1, rm_rst_n=0; timer cleared on entry and incremented every cycle.
REQ-024 WAIT exits: load_err -> FAULT, status=10; load_done -> SETTLE; timer all-ones -> FAULT, status=11.
REQ-025 WAIT priority: load_err over load_done over timeout on the same cycle.
REQ-026 SETTLE: decouple=1, rm_rst_n=1; stays exactly SETTLE_CYCLES cycles, then -> IDLE; status=01; swap_cnt+1.
REQ-027 swap_cnt wraps 255 -> 0.
REQ-028 FAULT: decouple=1, rm_rst_n=0; rising edge -> ISOLATE (retry); status is held until the next swap completes or fails.
REQ-029 led_out <= decouple ? SAFE_VALUE : rm_out, using the registered decouple value; latency is one cycle.
REQ-030 State outputs change on the clock edge that enters the state.

Reset
REQ-031 While rst_n=0: state=IDLE, decouple=0, rm_rst_n=0, load_start=0, led_out=SAFE_VALUE, status=00, swap_cnt=0, timer=0, edge register=0.
REQ-032 rm_rst_n goes to 1 on the first clock edge after rst_n deasserts.
REQ-033 Reset mid-swap aborts unconditionally; no pending request survives reset.

Configuration
REQ-034 Macro PR_DECOUPLE_RETRY_EN defined: the first load_err or timeout of a swap returns WAIT -> LOAD once, without touching status.
REQ-035 With PR_DECOUPLE_RETRY_EN, a second failure of the same swap goes to FAULT; the retry flag clears on ISOLATE entry.
REQ-036 Macro PR_DECOUPLE_RETRY_EN undefined: any failure goes directly to FAULT, and no retry logic is synthesised.

Verification (DRAIN=16, SETTLE=8, TIMEOUT_W=6)
REQ-037 Normal swap: swap_req rise at cycle 0, load_done at cycle 25.
  - load_start high at cycle 17 only.
  - decouple 1 over cycles 1..33, 0 from cycle 34.
  - swap_cnt=1, status=01.
REQ-038 Timeout, retry macro undefined: load_done never asserted.
  - FAULT reached 63 cycles after WAIT entry.
  - status=11, rm_rst_n=0, led_out=0000.
REQ-039 Simultaneous load_done and load_err in WAIT -> FAULT, status=10; with PR_DECOUPLE_RETRY_EN, second load_start pulse and FAULT only after the second error.
REQ-040 Ignored request: swap_req toggled during ISOLATE/WAIT causes no extra load_start; new rise in FAULT restarts at ISOLATE and completes with swap_cnt incremented.
REQ-041 Mid-swap reset: rst_n low during WAIT clears all outputs to reset values; 256 successful swaps wrap swap_cnt to 0.
